// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg -- shared AES-128 definitions for the decryptor slice.
//
// Contents:
//   NK, NR        key length in words and number of rounds (AES-128 only)
//   aes_state_t   4x4 byte state; byte (col c, row r) lives at s[3-c][3-r],
//                 so byte 0 of a 128-bit block (bits [127:120]) is s[3][3]
//   aes_fsm_e     decryptor FSM states
//   xtime, gf_mul GF(2^8) arithmetic, reduction polynomial 0x11B
//   sbox, inv_sbox S-box and inverse S-box (multiplicative inverse + affine)
//   rcon          key-schedule round constants, index 1..10
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam int unsigned NK = 4;
   localparam logic [3:0]  NR = 4'd10;

   typedef logic [3:0][3:0][7:0] aes_state_t;

   typedef enum logic [2:0] {
      IDLE,
      KEXP,
      INIT,
      ROUND,
      FINAL
   } aes_fsm_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8); it maps 0 to 0 as AES needs.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] a2, a4, a8, a16, a32, a64, a128;
      a2   = gf_mul(a, a);
      a4   = gf_mul(a2, a2);
      a8   = gf_mul(a4, a4);
      a16  = gf_mul(a8, a8);
      a32  = gf_mul(a16, a16);
      a64  = gf_mul(a32, a32);
      a128 = gf_mul(a64, a64);
      return gf_mul(gf_mul(gf_mul(a2, a4), gf_mul(a8, a16)),
                    gf_mul(gf_mul(a32, a64), a128));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   // Undo the affine transform first, then invert.
   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      logic [7:0] b;
      b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      return gf_inv(b);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      logic [7:0] r;
      case (i)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/aes_decryptor_if.sv
// ---------------------------------------------------------------------------
// aes_decryptor_if -- request/response bundle of the AES-128 decryptor.
//
//   start       requester -> decryptor  decrypt request (taken when ready=1)
//   ciphertext  requester -> decryptor  128-bit block, byte 0 = [127:120]
//   key         requester -> decryptor  128-bit cipher key
//   ready       decryptor -> requester  idle, a start will be accepted
//   plaintext   decryptor -> requester  result, valid from done onward
//   done        decryptor -> requester  one-cycle pulse, plaintext updated
//
// Modports: master = requester side, slave = decryptor side.
// ---------------------------------------------------------------------------
interface aes_decryptor_if;
   logic         start;
   logic [127:0] ciphertext;
   logic [127:0] key;
   logic         ready;
   logic [127:0] plaintext;
   logic         done;

   modport master (output start, ciphertext, key,
                   input  ready, plaintext, done);
   modport slave  (input  start, ciphertext, key,
                   output ready, plaintext, done);
endinterface

// File: rtl/aes_key_step.sv
// ---------------------------------------------------------------------------
// aes_key_step -- one combinational AES-128 key-schedule step.
//
//   prev_rk_i  in   round key i-1 (word 0 in [127:96])
//   rcon_i     in   Rcon[i]
//   next_rk_o  out  round key i
// ---------------------------------------------------------------------------
module aes_key_step
   import aes_pkg::*;
(
   input  logic [32*NK-1:0] prev_rk_i,
   input  logic [7:0]       rcon_i,
   output logic [32*NK-1:0] next_rk_o
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot, sub, temp;
   logic [31:0] n0, n1, n2, n3;

   always_comb begin
      w0   = prev_rk_i[127:96];
      w1   = prev_rk_i[95:64];
      w2   = prev_rk_i[63:32];
      w3   = prev_rk_i[31:0];
      rot  = {w3[23:0], w3[31:24]};
      sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
      temp = sub ^ {rcon_i, 24'h000000};
      n0   = w0 ^ temp;
      n1   = w1 ^ n0;
      n2   = w2 ^ n1;
      n3   = w3 ^ n2;
      next_rk_o = {n0, n1, n2, n3};
   end

endmodule

// File: rtl/aes_decryptor.sv
// ---------------------------------------------------------------------------
// aes_decryptor -- iterative AES-128 decryptor, one round per clock.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-high reset
//   bus   aes_decryptor_if.slave (start/ciphertext/key in,
//         ready/plaintext/done out)
//
// Sequence: IDLE -> KEXP (10 cycles, rk[1..10]) -> INIT (ct ^ rk[10])
//           -> ROUND (9 cycles, r = 9..1) -> FINAL (rk[0], done) -> IDLE.
// done rises 21 edges after the accepting edge.
//
// Optional feature: define AES_DEC_KEY_CACHE_EN to keep the expanded keys
// between operations; a start whose key matches the cached key skips KEXP
// (done 11 edges after accept).
// ---------------------------------------------------------------------------
module aes_decryptor
   import aes_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   aes_decryptor_if.slave bus
);

   aes_fsm_e     fsm_q, fsm_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [127:0] rk_q [0:10];
   logic         rk_we;
   logic [3:0]   rk_widx;
   logic [127:0] rk_wdata;
   logic [127:0] ct_q, ct_d;
   aes_state_t   st_q, st_d;
   logic [127:0] pt_q, pt_d;
   logic         done_q, done_d;
   logic         accept;
   logic         cache_hit;
   logic [3:0]   kidx;
   logic [127:0] kexp_rk;

   // ---------------- inverse round functions ----------------
   function automatic aes_state_t inv_shift_rows(input aes_state_t s);
      aes_state_t o;
      // row r is rotated right by r columns
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[3-c][3-r] = s[3-((c + 4 - r) % 4)][3-r];
      return o;
   endfunction

   function automatic aes_state_t inv_sub_bytes(input aes_state_t s);
      aes_state_t o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[c][r] = inv_sbox(s[c][r]);
      return o;
   endfunction

   function automatic aes_state_t inv_mix_columns(input aes_state_t s);
      aes_state_t o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[3-c][3];
         a1 = s[3-c][2];
         a2 = s[3-c][1];
         a3 = s[3-c][0];
         o[3-c][3] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[3-c][2] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[3-c][1] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[3-c][0] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

   function automatic aes_state_t final_round(input aes_state_t s, input logic [127:0] rk);
      return inv_sub_bytes(inv_shift_rows(s)) ^ rk;
   endfunction

   function automatic aes_state_t inv_round(input aes_state_t s, input logic [127:0] rk);
      return inv_mix_columns(final_round(s, rk));
   endfunction

   // ---------------- key schedule step ----------------
   // Outside KEXP the counter may be 0; clamp so the read stays in range.
   assign kidx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;

   aes_key_step u_key_step (
      .prev_rk_i (rk_q[kidx]),
      .rcon_i    (rcon(cnt_q)),
      .next_rk_o (kexp_rk)
   );

   assign accept = bus.start && (fsm_q == IDLE);

`ifdef AES_DEC_KEY_CACHE_EN
   logic cache_vld_q, cache_vld_d;
   // rk_q[0] always holds the key of the last accepted operation.
   assign cache_hit = cache_vld_q && (bus.key == rk_q[0]);

   always_ff @(posedge clk) begin
      if (rst) cache_vld_q <= 1'b0;
      else     cache_vld_q <= cache_vld_d;
   end

   always_comb begin
      cache_vld_d = cache_vld_q;
      // A new key overwrites the store, so the cache is only trusted again
      // once the full expansion has finished.
      if (accept && !cache_hit)                  cache_vld_d = 1'b0;
      if ((fsm_q == KEXP) && (cnt_q == NR))      cache_vld_d = 1'b1;
   end
`else
   assign cache_hit = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) fsm_q <= IDLE;
      else     fsm_q <= fsm_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE:    if (accept) fsm_d = cache_hit ? INIT : KEXP;
         KEXP:    if (cnt_q == NR) fsm_d = INIT;
         INIT:    fsm_d = ROUND;
         ROUND:   if (cnt_q == 4'd1) fsm_d = FINAL;
         FINAL:   fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      bus.ready     = (fsm_q == IDLE);
      bus.done      = done_q;
      bus.plaintext = pt_q;
   end

   // ---------------- datapath next state ----------------
   always_comb begin
      cnt_d    = cnt_q;
      ct_d     = ct_q;
      st_d     = st_q;
      pt_d     = pt_q;
      done_d   = 1'b0;
      rk_we    = 1'b0;
      rk_widx  = cnt_q;
      rk_wdata = kexp_rk;
      case (fsm_q)
         IDLE: begin
            if (accept) begin
               ct_d     = bus.ciphertext;
               rk_we    = 1'b1;
               rk_widx  = 4'd0;
               rk_wdata = bus.key;
               cnt_d    = cache_hit ? 4'd0 : 4'd1;
            end
         end
         KEXP: begin
            rk_we = 1'b1;
            if (cnt_q != NR) cnt_d = cnt_q + 4'd1;
         end
         INIT: begin
            st_d  = ct_q ^ rk_q[NR];
            cnt_d = NR - 4'd1;
         end
         ROUND: begin
            st_d = inv_round(st_q, rk_q[cnt_q]);
            if (cnt_q != 4'd1) cnt_d = cnt_q - 4'd1;
         end
         FINAL: begin
            pt_d   = final_round(st_q, rk_q[0]);
            done_d = 1'b1;
            cnt_d  = 4'd0;
         end
         default: ;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= 4'd0;
         ct_q   <= '0;
         st_q   <= '0;
         pt_q   <= '0;
         done_q <= 1'b0;
         for (int i = 0; i <= 10; i++) rk_q[i] <= '0;
      end else begin
         cnt_q  <= cnt_d;
         ct_q   <= ct_d;
         st_q   <= st_d;
         pt_q   <= pt_d;
         done_q <= done_d;
         if (rk_we) rk_q[rk_widx] <= rk_wdata;
      end
   end

endmodule

// File: tb/tb_aes_decryptor.sv
// ---------------------------------------------------------------------------
// tb_aes_decryptor -- directed bench for aes_decryptor using the FIPS-197
// Appendix B and C.1 vectors. Honours AES_DEC_KEY_CACHE_EN for the expected
// latency of operations whose key matches the previous key expansion.
// ---------------------------------------------------------------------------
module tb_aes_decryptor;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

   localparam int LAT_FULL = 21;
`ifdef AES_DEC_KEY_CACHE_EN
   localparam int LAT_HIT = 11;
`else
   localparam int LAT_HIT = 21;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   aes_decryptor_if bus();

   aes_decryptor dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Issue one request from an idle DUT and wait (bounded) for done.
   // Inputs are scrambled after the accepting edge. lat = 999 on timeout.
   task automatic run_op(input logic [127:0] ct, input logic [127:0] key,
                         output int lat, output logic [127:0] pt);
      @(negedge clk);
      bus.ciphertext = ct;
      bus.key        = key;
      bus.start      = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      bus.start      = 1'b0;
      bus.ciphertext = ~ct;
      bus.key        = ~key;
      lat = 999;
      pt  = '0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            lat = n;
            pt  = bus.plaintext;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      bus.start      = 1'b1;
      bus.ciphertext = C1;
      bus.key        = K1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      checks++; if (bus.plaintext !== 128'h0) begin errors++; $display("FAIL reset_pt: got %h expected 0", bus.plaintext); end
      @(negedge clk);
      rst       = 1'b0;
      bus.start = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", bus.ready); end
   endtask

   task automatic test_c1();
      int lat;
      logic [127:0] pt;
      run_op(C1, K1, lat, pt);
      checks++; if (pt !== P1) begin errors++; $display("FAIL c1_pt: got %h expected %h", pt, P1); end
      checks++; if (lat !== LAT_FULL) begin errors++; $display("FAIL c1_latency: got %0d expected %0d", lat, LAT_FULL); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL c1_done_pulse: got %b expected 0", bus.done); end
      checks++; if (bus.plaintext !== P1) begin errors++; $display("FAIL c1_pt_hold: got %h expected %h", bus.plaintext, P1); end
   endtask

   task automatic test_b();
      int lat;
      logic [127:0] pt;
      run_op(C2, K2, lat, pt);
      checks++; if (pt !== P2) begin errors++; $display("FAIL b_pt: got %h expected %h", pt, P2); end
      checks++; if (lat !== LAT_FULL) begin errors++; $display("FAIL b_latency: got %0d expected %0d", lat, LAT_FULL); end
   endtask

   // Extra start pulses sampled at edge 3 (KEXP) and edge 15 (ROUND).
   task automatic test_start_ignored();
      int dones = 0;
      int first_done = 0;
      int ready_bad = 0;
      logic [127:0] pt = '0;
      @(negedge clk);
      bus.ciphertext = C1;
      bus.key        = K1;
      bus.start      = 1'b1;
      @(posedge clk); #1;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         bus.start      = (n == 3) || (n == 15);
         bus.ciphertext = C2;
         bus.key        = K2;
         @(posedge clk); #1;
         if (bus.done) begin
            dones++;
            if (first_done == 0) begin
               first_done = n;
               pt = bus.plaintext;
            end
         end else if (first_done == 0 && bus.ready !== 1'b0) begin
            ready_bad++;
         end
      end
      checks++; if (ready_bad !== 0) begin errors++; $display("FAIL busy_ready_low: got %0d cycles with ready high, expected 0", ready_bad); end
      checks++; if (dones !== 1) begin errors++; $display("FAIL busy_single_done: got %0d done pulses expected 1", dones); end
      checks++; if (first_done !== LAT_FULL) begin errors++; $display("FAIL busy_latency: got %0d expected %0d", first_done, LAT_FULL); end
      checks++; if (pt !== P1) begin errors++; $display("FAIL busy_pt: got %h expected %h", pt, P1); end
   endtask

   // Reset sampled at edge 16, i.e. the fifth ROUND cycle (r = 5).
   task automatic test_rst_mid();
      int early_done = 0;
      int late_done = 0;
      int lat;
      logic [127:0] pt;
      @(negedge clk);
      bus.ciphertext = C2;
      bus.key        = K2;
      bus.start      = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int n = 1; n <= 15; n++) begin
         @(posedge clk); #1;
         if (bus.done) early_done++;
      end
      checks++; if (bus.plaintext !== P1) begin errors++; $display("FAIL midop_pt_hold: got %h expected %h", bus.plaintext, P1); end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (early_done !== 0) begin errors++; $display("FAIL abort_early_done: got %0d expected 0", early_done); end
      checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", bus.ready); end
      checks++; if (bus.plaintext !== 128'h0) begin errors++; $display("FAIL abort_pt: got %h expected 0", bus.plaintext); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", bus.done); end
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 25; n++) begin
         @(posedge clk); #1;
         if (bus.done) late_done++;
      end
      checks++; if (late_done !== 0) begin errors++; $display("FAIL abort_late_done: got %0d expected 0", late_done); end
      run_op(C1, K1, lat, pt);
      checks++; if (pt !== P1) begin errors++; $display("FAIL after_abort_pt: got %h expected %h", pt, P1); end
      checks++; if (lat !== LAT_FULL) begin errors++; $display("FAIL after_abort_latency: got %0d expected %0d", lat, LAT_FULL); end
   endtask

   // start held high: C.1 then B, the second accepted in the done cycle.
   task automatic test_back_to_back();
      int d1 = 0;
      int d2 = 0;
      logic rdy_at_done = 1'b0;
      logic rdy_after = 1'b1;
      logic [127:0] pt1 = '0;
      logic [127:0] pt2 = '0;
      logic [127:0] pt_mid = '0;
      @(negedge clk);
      bus.ciphertext = C1;
      bus.key        = K1;
      bus.start      = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      bus.ciphertext = C2;
      bus.key        = K2;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            if (d1 == 0) begin
               d1 = n;
               pt1 = bus.plaintext;
               rdy_at_done = bus.ready;
            end else begin
               d2 = n;
               pt2 = bus.plaintext;
               break;
            end
         end
         if (d1 != 0 && n == d1 + 1) rdy_after = bus.ready;
         if (d1 != 0 && n == d1 + 5) pt_mid = bus.plaintext;
      end
      @(negedge clk);
      bus.start = 1'b0;
      checks++; if (pt1 !== P1) begin errors++; $display("FAIL b2b_pt1: got %h expected %h", pt1, P1); end
      checks++; if (d1 !== LAT_HIT) begin errors++; $display("FAIL b2b_latency1: got %0d expected %0d", d1, LAT_HIT); end
      checks++; if (rdy_at_done !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done: got %b expected 1", rdy_at_done); end
      checks++; if (rdy_after !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: got ready %b expected 0", rdy_after); end
      checks++; if (pt_mid !== P1) begin errors++; $display("FAIL b2b_pt_hold: got %h expected %h", pt_mid, P1); end
      checks++; if (pt2 !== P2) begin errors++; $display("FAIL b2b_pt2: got %h expected %h", pt2, P2); end
      checks++; if (d2 - d1 !== 22) begin errors++; $display("FAIL b2b_spacing: got %0d expected 22", d2 - d1); end
   endtask

   // C.1 twice (second reuses the key), then B with a new key.
   task automatic test_key_reuse();
      int lat;
      logic [127:0] pt;
      run_op(C1, K1, lat, pt);
      checks++; if (pt !== P1) begin errors++; $display("FAIL reuse1_pt: got %h expected %h", pt, P1); end
      checks++; if (lat !== LAT_FULL) begin errors++; $display("FAIL reuse1_latency: got %0d expected %0d", lat, LAT_FULL); end
      run_op(C1, K1, lat, pt);
      checks++; if (pt !== P1) begin errors++; $display("FAIL reuse2_pt: got %h expected %h", pt, P1); end
      checks++; if (lat !== LAT_HIT) begin errors++; $display("FAIL reuse2_latency: got %0d expected %0d", lat, LAT_HIT); end
      run_op(C2, K2, lat, pt);
      checks++; if (pt !== P2) begin errors++; $display("FAIL reuse3_pt: got %h expected %h", pt, P2); end
      checks++; if (lat !== LAT_FULL) begin errors++; $display("FAIL reuse3_latency: got %0d expected %0d", lat, LAT_FULL); end
   endtask

   initial begin
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.ciphertext = '0;
      bus.key        = '0;
      test_reset();
      test_c1();
      test_b();
      test_start_ignored();
      test_rst_mid();
      test_back_to_back();
      test_key_reuse();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_decryptor.md
AES_DECRYPTOR -- requirements
Module: aes_decryptor

Interface
REQ-001 The block SHALL have no parameters; AES-128 only (Nk=4, Nr=10), fixed by package constants.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to decrypt; sampled only when ready=1.
REQ-005 ciphertext  input  128  block to decrypt; byte 0 = bits [127:120], column-major state per FIPS-197.
REQ-006 key  input  128  cipher key (same key used to encrypt); same byte order.
REQ-007 ready  output  1  high in IDLE only; start accepted on the edge where start=1 and ready=1.
REQ-008 plaintext  output  128  decrypted block; valid from done onward until the next accepted start.
REQ-009 done  output  1  one-cycle pulse when plaintext becomes valid.

Function
REQ-010 On accept, the block SHALL capture ciphertext and key into internal registers; later input changes SHALL NOT affect the operation in progress.
REQ-011 FSM states SHALL be IDLE, KEXP, INIT, ROUND, FINAL.
- IDLE -> KEXP on accept.
- KEXP -> INIT after 10 cycles.
- INIT -> ROUND.
- ROUND -> FINAL after 9 cycles.
- FINAL -> IDLE.
REQ-012 KEXP SHALL compute one round key per cycle, rk[1]..rk[10], from rk[0]=key, using RotWord/SubWord/Rcon, and store all 11 round keys.
REQ-013 INIT SHALL load state = ciphertext XOR rk[10].
REQ-014 ROUND cycle for r=9 down to 1 SHALL apply InvShiftRows, InvSubBytes, AddRoundKey(rk[r]), InvMixColumns, in that order.
REQ-015 FINAL SHALL apply InvShiftRows, InvSubBytes, AddRoundKey(rk[0]), write plaintext and pulse done.
REQ-016 Latency SHALL be exactly 21 clock edges from the accepting edge to the edge that raises done; throughput is one block per 22 cycles.
REQ-017 InvMixColumns SHALL use GF(2^8) multiplies by 0x09/0x0B/0x0D/0x0E with reduction polynomial 0x11B.
REQ-018 start while ready=0 SHALL be ignored, with no queuing.
REQ-019 start asserted in the cycle done=1 SHALL be accepted, since ready is already high in that cycle.
REQ-020 A 4-bit round counter SHALL count 1..10 in KEXP and 9..1 in ROUND; it SHALL never wrap outside these ranges.
REQ-021 plaintext SHALL hold its last value when idle and during a following operation until overwritten at FINAL.

Reset
REQ-022 rst SHALL override start and all FSM activity in the same edge.
REQ-023 After rst:
- state = IDLE
- ready = 1
- done = 0
- plaintext = 0
- round counter = 0
- round-key store and key-cache valid flag cleared
REQ-024 rst asserted mid-operation SHALL abort without a done pulse; the next accept SHALL start a fresh operation.

Configuration
REQ-025 Macro AES_DEC_KEY_CACHE_EN, when defined, SHALL keep the expanded round keys and the captured key after an operation completes.
REQ-026 With AES_DEC_KEY_CACHE_EN defined:
- If the accepted key equals the cached key and the cache is valid, IDLE SHALL go directly to INIT, skipping KEXP; latency becomes 11 edges.
- If the keys differ, full KEXP SHALL run.
- rst SHALL invalidate the cache.
REQ-027 Without AES_DEC_KEY_CACHE_EN, every operation SHALL run KEXP, with fixed latency of 21.

Structure
REQ-028 Package aes_pkg SHALL hold:
- NR=10 and NK=4
- the state typedef (4x4 bytes)
- sbox and inv_sbox lookup functions
- the Rcon table
- the xtime/gf_mul functions
- the FSM state enum
REQ-029 One sub-module, aes_key_step, SHALL produce rk[i] from rk[i-1] and Rcon[i] combinationally; aes_decryptor instantiates it once.
REQ-030 Inverse round logic SHALL be combinational functions inside aes_decryptor; there SHALL be no per-round instances.

Verification
REQ-031 The bench SHALL cover FIPS-197 C.1:
- Stimulus: key=000102030405060708090a0b0c0d0e0f, ct=69c4e0d86a7b0430d8cdb78070b4c55a.
- Response: pt=00112233445566778899aabbccddeeff, done exactly 21 edges after accept.
REQ-032 The bench SHALL cover FIPS-197 Appendix B:
- Stimulus: key=2b7e151628aed2a6abf7158809cf4f3c, ct=3925841d02dc09fbdc118597196a0b32.
- Response: pt=3243f6a8885a308d313198a2e0370734.
REQ-033 The bench SHALL cover start pulsed during KEXP and during ROUND of an operation: ignored, single done, correct pt, ready=0 throughout.
REQ-034 The bench SHALL cover rst asserted in ROUND cycle 5:
- Response: no done; ready=1, plaintext=0 next cycle.
- Then run the C.1 vector: correct result at latency 21.
REQ-035 The bench SHALL cover back-to-back operations with start held high, C.1 then B: second accepted in the done cycle; both outputs correct.
REQ-036 With AES_DEC_KEY_CACHE_EN defined:
- Two C.1 decryptions with the same key: second done at 11 edges.
- Then the B vector: 21 edges, correct pt.
